// File: rtl/aes_inv_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_round_ctrl_if
// Description : Handshake bundle for the AES-128 inverse round sequencer.
//               Groups the ciphertext input stream, the round-key fetch
//               channel and the plaintext output stream.
//   in_valid/in_ready/in_data    : ciphertext stream (byte 0 at bits [0:7])
//   key_req/key_idx              : round-key request, index NR..0
//   key_valid/round_key          : round key returned for key_idx
//   out_valid/out_ready/out_data : plaintext stream
//   busy                         : sequencer not idle
//   master : drives the stimulus side (source, key store, sink)
//   slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_round_ctrl_if #(
   parameter int IDX_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [0:127]     in_data;
   logic             key_req;
   logic [IDX_W-1:0] key_idx;
   logic             key_valid;
   logic [0:127]     round_key;
   logic             out_valid;
   logic             out_ready;
   logic [0:127]     out_data;
   logic             busy;

   modport master (
      output in_valid, in_data, key_valid, round_key, out_ready,
      input  in_ready, key_req, key_idx, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, key_valid, round_key, out_ready,
      output in_ready, key_req, key_idx, out_valid, out_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_round_ctrl
// Description : Iterative AES-128 inverse-cipher round sequencer. Holds the
//               128-bit state and applies one inverse round per accepted
//               round key, fetching keys NR down to 0 over key_req/key_valid.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - slave view of aes_inv_round_ctrl_if (ciphertext in,
//                       key fetch, plaintext out, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_round_ctrl #(
   parameter int NR    = 10,
   parameter int IDX_W = 4
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   aes_inv_round_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // ---------------- GF(2^8) helpers and round functions ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a12  = gmul(gmul(a3, a3), gmul(a3, a3));
      a15  = gmul(a12, a3);
      a240 = gmul(a15, a15);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction

   // Inverse affine transform followed by field inversion.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   // Byte k sits at row k%4, column k/4; row r rotates right by r.
   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      return o;
   endfunction

   function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int k = 0; k < 16; k++)
         o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
      return o;
   endfunction

   function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c      +: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
         o[32*c + 8  +: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
         o[32*c + 16 +: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
         o[32*c + 24 +: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
      end
      return o;
   endfunction

   // ---------------- registers ----------------
   state_t           r_state;
   logic [0:127]     r_blk;
   logic [IDX_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_key_req;
   logic [IDX_W-1:0] r_key_idx;
   logic             r_out_valid;
   logic [0:127]     r_out_data;
   logic             r_busy;

   // ---------------- datapath ----------------
   logic [0:127] w_ark;     // AddRoundKey(InvSubBytes(InvShiftRows(state)))
   logic [0:127] w_round;   // full middle round
   logic         w_key_ok;

   assign w_ark    = inv_sub_bytes(inv_shift_rows(r_blk)) ^ bus.round_key;
   assign w_round  = inv_mix_columns(w_ark);
   assign w_key_ok = r_key_req & bus.key_valid;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_blk       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_key_req   <= 1'b0;
         r_key_idx   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_blk      <= bus.in_data;
                  r_cnt      <= IDX_W'(NR);
                  r_in_ready <= 1'b0;
                  r_key_req  <= 1'b1;
                  r_key_idx  <= IDX_W'(NR);
                  r_busy     <= 1'b1;
                  r_state    <= S_INIT;
               end
            end
            S_INIT: begin
               if (w_key_ok) begin
                  r_blk     <= r_blk ^ bus.round_key;
                  r_cnt     <= IDX_W'(NR - 1);
                  r_key_idx <= IDX_W'(NR - 1);
                  r_state   <= S_ROUND;
               end
            end
            S_ROUND: begin
               if (w_key_ok) begin
                  r_blk <= w_round;
                  r_cnt <= r_cnt - IDX_W'(1);
                  if (r_cnt == IDX_W'(1)) begin
                     r_key_idx <= '0;
                     r_state   <= S_FINAL;
                  end else begin
                     r_key_idx <= r_cnt - IDX_W'(1);
                  end
               end
            end
            S_FINAL: begin
               if (w_key_ok) begin
                  r_out_data  <= w_ark;
                  r_out_valid <= 1'b1;
                  r_key_req   <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // in_ready only rises after the output handshake, so the two
               // transfers can never share a cycle.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
               r_key_req  <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.key_req   = r_key_req;
   assign bus.key_idx   = r_key_idx;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.busy      = r_busy;

endmodule
`default_nettype wire
